shared_ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one single-port "no change" RAM (1-cycle registered read, output held when not reading). Accepts at most one access per cycle from port 0 or port 1, drives the RAM command pins from registers, and returns read data to the issuing port only. Shares one work/video RAM between a CPU-side and a PPU/DMA-side client in the NES top level.

---
 rtl/shared_ram_arbiter.sv | 112 +++++++++++
 tb/tb_shared_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arbiter.sv
// Two-port arbiter/sequencer for one single-port "no change" RAM with a 1-cycle registered read.
// Issues at most one access per cycle and routes read data back to the issuing port.
module shared_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 2048,
  parameter string       ARB_MODE   = "ROUND_ROBIN",
  localparam int unsigned AW        = $clog2(RAM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [AW-1:0]         addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic [AW-1:0]         addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic                  ram_rd_o,
  output logic                  ram_wr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  localparam bit FixedMode = (ARB_MODE == "FIXED");

  logic                  last_q;
  logic                  sel1;
  logic                  grant;
  logic                  gnt_we;
  logic [AW-1:0]         gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;

  logic                  ram_rd_q, ram_wr_q;
  logic [AW-1:0]         ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_din_q;

  // Read tags: stage 1 tracks the RAM command cycle, stage 2 the RAM data cycle.
  logic                  tag1_valid_q, tag1_port_q;
  logic                  tag2_valid_q, tag2_port_q;

  logic                  rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  always_comb begin
    // Port 1 wins when alone, or on a round-robin conflict where port 0 went last.
    sel1      = req1_i & (~req0_i | (~FixedMode & ~last_q));
    gnt1_o    = sel1;
    gnt0_o    = req0_i & ~sel1;
    grant     = gnt0_o | gnt1_o;
    gnt_we    = sel1 ? we1_i    : we0_i;
    gnt_addr  = sel1 ? addr1_i  : addr0_i;
    gnt_wdata = sel1 ? wdata1_i : wdata0_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q       <= 1'b1;
      ram_rd_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      tag1_valid_q <= 1'b0;
      tag1_port_q  <= 1'b0;
      tag2_valid_q <= 1'b0;
      tag2_port_q  <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ram_rd_q <= grant & ~gnt_we;
      ram_wr_q <= grant & gnt_we;
      if (grant) begin
        last_q     <= sel1;
        ram_addr_q <= gnt_addr;
        if (gnt_we) begin
          ram_din_q <= gnt_wdata;
        end
      end
      tag1_valid_q <= grant & ~gnt_we;
      tag1_port_q  <= sel1;
      tag2_valid_q <= tag1_valid_q;
      tag2_port_q  <= tag1_port_q;
      rvalid0_q    <= tag2_valid_q & ~tag2_port_q;
      rvalid1_q    <= tag2_valid_q & tag2_port_q;
      if (tag2_valid_q && !tag2_port_q) begin
        rdata0_q <= ram_dout_i;
      end
      if (tag2_valid_q && tag2_port_q) begin
        rdata1_q <= ram_dout_i;
      end
    end
  end

  assign ram_rd_o   = ram_rd_q;
  assign ram_wr_o   = ram_wr_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign rvalid0_o  = rvalid0_q;
  assign rvalid1_o  = rvalid1_q;
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own RAM, checked against a transaction-level model of grants and responses.
module tb_shared_ram_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0_w [2];
  logic          gnt1_w [2];
  logic          rv0_w [2];
  logic          rv1_w [2];
  logic          ram_rd_w [2];
  logic          ram_wr_w [2];
  logic [DW-1:0] rdata0_w [2];
  logic [DW-1:0] rdata1_w [2];
  logic [DW-1:0] din_w [2];
  logic [AW-1:0] raddr_w [2];
  logic [DW-1:0] dout_r [2];
  logic [DW-1:0] mem [2][DEPTH];

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  shared_ram_arbiter #(.ARB_MODE("ROUND_ROBIN")) u_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0_w[0]), .gnt1_o(gnt1_w[0]), .rvalid0_o(rv0_w[0]), .rvalid1_o(rv1_w[0]),
    .rdata0_o(rdata0_w[0]), .rdata1_o(rdata1_w[0]), .ram_addr_o(raddr_w[0]),
    .ram_rd_o(ram_rd_w[0]), .ram_wr_o(ram_wr_w[0]), .ram_din_o(din_w[0]),
    .ram_dout_i(dout_r[0])
  );

  shared_ram_arbiter #(.ARB_MODE("FIXED")) u_fx (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0_w[1]), .gnt1_o(gnt1_w[1]), .rvalid0_o(rv0_w[1]), .rvalid1_o(rv1_w[1]),
    .rdata0_o(rdata0_w[1]), .rdata1_o(rdata1_w[1]), .ram_addr_o(raddr_w[1]),
    .ram_rd_o(ram_rd_w[1]), .ram_wr_o(ram_wr_w[1]), .ram_din_o(din_w[1]),
    .ram_dout_i(dout_r[1])
  );

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 16) ? 8'h5A : (8'(i) ^ 8'hA5);
  endfunction

  // No-change RAMs; contents are reloaded while reset is held.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[m][i] <= init_val(i);
      end else begin
        if (ram_wr_w[m]) mem[m][raddr_w[m]] <= din_w[m];
        if (ram_rd_w[m]) dout_r[m] <= mem[m][raddr_w[m]];
      end
    end
  end

  typedef struct {
    int            due;
    int            mode;
    int            port;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         pend[$];
  int            last_m [2];
  logic          e_rd [2];
  logic          e_wr [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_din [2];
  logic          e_rv [2][2];
  logic [DW-1:0] e_rdata [2][2];
  logic [DW-1:0] shadow [2][DEPTH];
  int            cyc;
  int            n_chk;
  int            n_pass;

  task automatic chk(string tag, int m, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut=%0d observed=%0h expected=%0h cyc=%0d", tag, m, obs, exp, cyc);
  endtask

  task automatic model_reset();
    pend.delete();
    for (int m = 0; m < 2; m++) begin
      last_m[m] = 1;
      e_rd[m]   = 1'b0;
      e_wr[m]   = 1'b0;
      e_addr[m] = '0;
      e_din[m]  = '0;
      for (int p = 0; p < 2; p++) begin
        e_rv[m][p]    = 1'b0;
        e_rdata[m][p] = '0;
      end
      for (int i = 0; i < DEPTH; i++) shadow[m][i] = init_val(i);
    end
  endtask

  // Expected winner for instance m: -1 none, else port number.
  function automatic int exp_gnt(int m);
    if (req0 && req1) return (m == 1) ? 0 : ((last_m[m] == 1) ? 0 : 1);
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic tick();
    int            g;
    int            k;
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      g = exp_gnt(m);
      chk("gnt0", m, 32'(gnt0_w[m]), 32'(g == 0));
      chk("gnt1", m, 32'(gnt1_w[m]), 32'(g == 1));
      chk("ram_rd", m, 32'(ram_rd_w[m]), 32'(e_rd[m]));
      chk("ram_wr", m, 32'(ram_wr_w[m]), 32'(e_wr[m]));
      chk("ram_addr", m, 32'(raddr_w[m]), 32'(e_addr[m]));
      chk("ram_din", m, 32'(din_w[m]), 32'(e_din[m]));
      chk("rvalid0", m, 32'(rv0_w[m]), 32'(e_rv[m][0]));
      chk("rvalid1", m, 32'(rv1_w[m]), 32'(e_rv[m][1]));
      chk("rdata0", m, 32'(rdata0_w[m]), 32'(e_rdata[m][0]));
      chk("rdata1", m, 32'(rdata1_w[m]), 32'(e_rdata[m][1]));
    end
    if (!rst) begin
      k = cyc + 1;
      for (int m = 0; m < 2; m++) begin
        e_rv[m][0] = 1'b0;
        e_rv[m][1] = 1'b0;
      end
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == k) begin
          e_rv[pend[i].mode][pend[i].port]    = 1'b1;
          e_rdata[pend[i].mode][pend[i].port] = pend[i].data;
          pend.delete(i);
        end
      end
      for (int m = 0; m < 2; m++) begin
        g = exp_gnt(m);
        if (g < 0) begin
          e_rd[m] = 1'b0;
          e_wr[m] = 1'b0;
        end else begin
          a = (g == 1) ? addr1 : addr0;
          w = (g == 1) ? we1 : we0;
          d = (g == 1) ? wdata1 : wdata0;
          last_m[m] = g;
          e_addr[m] = a;
          e_wr[m]   = w;
          e_rd[m]   = !w;
          if (w) begin
            e_din[m]     = d;
            shadow[m][a] = d;
          end else begin
            pend.push_back('{due: k + 2, mode: m, port: g, data: shadow[m][a]});
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(logic r0, logic w0, int a0, int d0, logic r1, logic w1, int a1, int d1);
    req0 = r0; we0 = w0; addr0 = AW'(a0); wdata0 = DW'(d0);
    req1 = r1; we1 = w1; addr1 = AW'(a1); wdata1 = DW'(d1);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single read of preloaded 0x5A at 0x010.
    drive(1, 0, 'h010, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Port 1 write then read back-to-back.
    drive(0, 0, 0, 0, 1, 1, 'h7FF, 'hC3);
    tick();
    drive(0, 0, 0, 0, 1, 0, 'h7FF, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Continuous contention, then req0 drops for one cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 'h100 + i, 0, 1, 0, 'h200 + i, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 'h2FF, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Reset one cycle after a read grant; first conflict afterwards goes to port 0.
    drive(1, 0, 'h010, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    drive(1, 0, 'h011, 0, 1, 0, 'h012, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    // Write then idle: command registers hold.
    drive(1, 1, 'h020, 'h33, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    // Random mix over a small address window to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
